pg_masked_prefix_adder: RTL and testbench
=========================================

// Module: pg_masked_prefix_adder
// PURPOSE
//   First-order Boolean-masked WIDTH-bit adder built on a Kogge-Stone prefix tree.
//   Stage 0 computes masked propagate/generate per bit with 2-share AND gadgets.
//   Each prefix level is one registered pipeline stage, so throughput is one add per cycle.
//   Sits in the masked datapath wherever arithmetic on 2-share operands is needed.
//   It replaces the per-bit single-stage PG cell.
// PARAMETERS
//   WIDTH   8   operand width; power of 2, >= 2
//   LEVELS  $clog2(WIDTH)   localparam, number of prefix levels
//   RW      WIDTH*(1+2*LEVELS)   localparam, width of the fresh-randomness bus
// PORTS
//   clk      in   1      clock; all state updates on posedge clk
//   rst      in   1      synchronous, active-high reset
//   i_en     in   1      pipeline enable; 0 = every stage holds
//   i_valid  in   1      input operands valid this cycle
//   i_a0     in   WIDTH  share 0 of A (A = i_a0 ^ i_a1)
//   i_a1     in   WIDTH  share 1 of A
//   i_b0     in   WIDTH  share 0 of B
//   i_b1     in   WIDTH  share 1 of B
//   i_r      in   RW     fresh uniform random bits, consumed when i_en=1
//   o_valid  out  1      result valid
//   o_s0     out  WIDTH  share 0 of S = (A+B) mod 2^WIDTH
//   o_s1     out  WIDTH  share 1 of S
//   o_c0     out  1      share 0 of carry-out
//   o_c1     out  1      share 1 of carry-out
// BEHAVIOUR
//   AND gadget z=x&y with random bit r:
//     z0 = x0&y0 ^ x0&y1 ^ r
//     z1 = x1&y1 ^ x1&y0 ^ r
//   Linear operations (XOR) are applied share-wise. Shares are never combined.
//   Stage 0 (registered):
//     p = a^b, share-wise.
//     g = gadget(a,b), with bit i using i_r[i].
//     p is also copied into a delay line as porig.
//   Level k=1..LEVELS (registered), with d = 2^(k-1) and base = WIDTH*(2k-1):
//     for i >= d: G[i] ^= gadget(P[i], G[i-d]) using i_r[base+i].
//     for i >= d: P[i]  = gadget(P[i], P[i-d]) using i_r[base+WIDTH+i].
//     for i < d: G and P pass through unchanged; their i_r bits are ignored.
//   Output stage (registered):
//     s[0] = porig[0]
//     s[i] = porig[i] ^ G[i-1], share-wise
//     c = G[WIDTH-1]
//     carry-in is 0.
//   Latency: LEVELS+2 cycles of i_en=1 from sampled input to output (5 for WIDTH=8).
//   Valid: i_valid moves through a shift register of the same depth, alongside the data.
//     No backpressure; results emerge in input order.
//   i_en=0: all data registers, the valid pipe and outputs hold; i_r is ignored.
//   Every data register updates whenever i_en=1, regardless of valid.
//     Outputs are defined only while o_valid=1.
//   Reset (rst=1 at posedge, takes priority over i_en):
//     all pipeline registers, o_s0/o_s1/o_c0/o_c1 and o_valid go to 0.
//     In-flight operations are discarded.
//   After rst deasserts, the first o_valid=1 appears LEVELS+2 enabled cycles after the first i_valid.
//   Wrap-around: the sum is mod 2^WIDTH; the overflow bit appears only on c.
//   Output shares vary with i_r. The unmasked values S and c must not depend on i_r.
// TESTING
//   T1 WIDTH=8, A=0x5A, B=0x3C, random shares and r
//      -> 5 cycles later o_valid=1, o_s0^o_s1=0x96, o_c0^o_c1=0.
//   T2 A=0xFF, B=0x01 -> S=0x00, c=1.
//      A=0x80, B=0x80 -> S=0x00, c=1.
//      A=0, B=0 -> S=0, c=0.
//   T3 1000 back-to-back random vectors, i_valid=1 every cycle, fresh i_r
//      -> one result per cycle, in order, all matching a reference model.
//      Also check that o_s0 alone is not constant across identical A,B.
//   T4 drop i_en for 3 cycles with 4 ops in flight
//      -> outputs and o_valid frozen; afterwards all 4 results appear exactly once, in order.
//   T5 assert rst for 1 cycle with 3 ops in flight
//      -> next cycle o_valid=0 and outputs 0; no stale result ever appears.
//   T6 WIDTH=2 and WIDTH=4 builds, exhaustive A,B with random masks
//      -> every S and c correct.

Source files
------------

// File: rtl/pg_masked_prefix_adder.sv
// Two-share Boolean-masked adder: masked PG generation, a registered Kogge-Stone
// prefix tree (one level per stage) and a registered sum/carry output stage.
module pg_masked_prefix_adder #(
    parameter  int WIDTH  = 8,
    localparam int LEVELS = $clog2(WIDTH),
    localparam int RW     = WIDTH * (1 + 2 * LEVELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_b1,
    input  logic [RW-1:0]    i_r,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic             o_c0,
    output logic             o_c1
);

    // Masked AND: returns {z1, z0}; r refreshes the cross-share terms
    function automatic logic [1:0] and_gadget(input logic x0, input logic x1,
                                              input logic y0, input logic y1,
                                              input logic r);
        logic z0;
        logic z1;
        z0 = (x0 & y0) ^ (x0 & y1) ^ r;
        z1 = (x1 & y1) ^ (x1 & y0) ^ r;
        return {z1, z0};
    endfunction

    logic [WIDTH-1:0] r_p0  [0:LEVELS];
    logic [WIDTH-1:0] r_p1  [0:LEVELS];
    logic [WIDTH-1:0] r_g0  [0:LEVELS];
    logic [WIDTH-1:0] r_g1  [0:LEVELS];
    logic [WIDTH-1:0] r_po0 [0:LEVELS];
    logic [WIDTH-1:0] r_po1 [0:LEVELS];
    logic [LEVELS:0]  r_vld;

    logic [WIDTH-1:0] w_p0_nxt [0:LEVELS];
    logic [WIDTH-1:0] w_p1_nxt [0:LEVELS];
    logic [WIDTH-1:0] w_g0_nxt [0:LEVELS];
    logic [WIDTH-1:0] w_g1_nxt [0:LEVELS];

    assign w_p0_nxt[0] = i_a0 ^ i_b0;
    assign w_p1_nxt[0] = i_a1 ^ i_b1;

    genvar k, i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_st0
            logic [1:0] w_zg;
            assign w_zg = and_gadget(i_a0[i], i_a1[i], i_b0[i], i_b1[i], i_r[i]);
            assign w_g0_nxt[0][i] = w_zg[0];
            assign w_g1_nxt[0][i] = w_zg[1];
        end

        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int D    = 1 << (k - 1);
            localparam int BASE = WIDTH * (2 * k - 1);
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= D) begin : g_op
                    logic [1:0] w_zg;
                    logic [1:0] w_zp;
                    // Old P is used for both gadgets; G and P spans stay disjoint so XOR acts as OR
                    assign w_zg = and_gadget(r_p0[k-1][i], r_p1[k-1][i],
                                             r_g0[k-1][i-D], r_g1[k-1][i-D], i_r[BASE+i]);
                    assign w_zp = and_gadget(r_p0[k-1][i], r_p1[k-1][i],
                                             r_p0[k-1][i-D], r_p1[k-1][i-D], i_r[BASE+WIDTH+i]);
                    assign w_g0_nxt[k][i] = r_g0[k-1][i] ^ w_zg[0];
                    assign w_g1_nxt[k][i] = r_g1[k-1][i] ^ w_zg[1];
                    assign w_p0_nxt[k][i] = w_zp[0];
                    assign w_p1_nxt[k][i] = w_zp[1];
                end else begin : g_pass
                    logic w_unused_r;
                    assign w_unused_r     = i_r[BASE+i] ^ i_r[BASE+WIDTH+i];
                    assign w_g0_nxt[k][i] = r_g0[k-1][i];
                    assign w_g1_nxt[k][i] = r_g1[k-1][i];
                    assign w_p0_nxt[k][i] = r_p0[k-1][i];
                    assign w_p1_nxt[k][i] = r_p1[k-1][i];
                end
            end
        end
    endgenerate

    // Pipeline registers, valid pipe and output stage; reset beats enable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LEVELS; s++) begin
                r_p0[s]  <= {WIDTH{1'b0}};
                r_p1[s]  <= {WIDTH{1'b0}};
                r_g0[s]  <= {WIDTH{1'b0}};
                r_g1[s]  <= {WIDTH{1'b0}};
                r_po0[s] <= {WIDTH{1'b0}};
                r_po1[s] <= {WIDTH{1'b0}};
            end
            r_vld   <= {(LEVELS+1){1'b0}};
            o_valid <= 1'b0;
            o_s0    <= {WIDTH{1'b0}};
            o_s1    <= {WIDTH{1'b0}};
            o_c0    <= 1'b0;
            o_c1    <= 1'b0;
        end else if (i_en) begin
            for (int s = 0; s <= LEVELS; s++) begin
                r_p0[s] <= w_p0_nxt[s];
                r_p1[s] <= w_p1_nxt[s];
                r_g0[s] <= w_g0_nxt[s];
                r_g1[s] <= w_g1_nxt[s];
            end
            r_po0[0] <= w_p0_nxt[0];
            r_po1[0] <= w_p1_nxt[0];
            for (int s = 1; s <= LEVELS; s++) begin
                r_po0[s] <= r_po0[s-1];
                r_po1[s] <= r_po1[s-1];
            end
            r_vld   <= {r_vld[LEVELS-1:0], i_valid};
            o_valid <= r_vld[LEVELS];
            // Carry into bit i is the group generate of bits [i-1:0]; carry-in is zero
            o_s0    <= r_po0[LEVELS] ^ {r_g0[LEVELS][WIDTH-2:0], 1'b0};
            o_s1    <= r_po1[LEVELS] ^ {r_g1[LEVELS][WIDTH-2:0], 1'b0};
            o_c0    <= r_g0[LEVELS][WIDTH-1];
            o_c1    <= r_g1[LEVELS][WIDTH-1];
        end
    end

endmodule

// File: tb/tb_pg_masked_prefix_adder.sv
// Bench for pg_masked_prefix_adder: WIDTH 8/4/2 instances checked every cycle against
// an arithmetic delay-line model, plus directed literal checks.
module tb_pg_masked_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, i_en, i_valid;
    logic [7:0]  a80, a81, b80, b81, s80, s81;
    logic [3:0]  a40, a41, b40, b41, s40, s41;
    logic [1:0]  a20, a21, b20, b21, s20, s21;
    logic [55:0] r8;
    logic [19:0] r4;
    logic [5:0]  r2;
    logic ov8, c80, c81, ov4, c40, c41, ov2, c20, c21;

    pg_masked_prefix_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
        .i_a0(a80), .i_a1(a81), .i_b0(b80), .i_b1(b81), .i_r(r8),
        .o_valid(ov8), .o_s0(s80), .o_s1(s81), .o_c0(c80), .o_c1(c81));

    pg_masked_prefix_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
        .i_a0(a40), .i_a1(a41), .i_b0(b40), .i_b1(b41), .i_r(r4),
        .o_valid(ov4), .o_s0(s40), .o_s1(s41), .o_c0(c40), .o_c1(c41));

    pg_masked_prefix_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
        .i_a0(a20), .i_a1(a21), .i_b0(b20), .i_b1(b21), .i_r(r2),
        .o_valid(ov2), .o_s0(s20), .o_s1(s21), .o_c0(c20), .o_c1(c21));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // {carry, sum} of a w-bit addition, sum zero-extended to 8 bits
    function automatic logic [8:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        logic [8:0] mask;
        sum  = {1'b0, a} + {1'b0, b};
        mask = (9'd1 << w) - 9'd1;
        return {sum[w], sum[7:0] & mask[7:0]};
    endfunction

    // Model entries: {valid, carry, sum}; the last entry is what the outputs must show
    logic [9:0] m8 [0:4];
    logic [9:0] m4 [0:3];
    logic [9:0] m2 [0:2];
    logic hold_q = 1'b0;

    always @(posedge clk) begin
        hold_q <= !rst && !i_en;
        if (rst) begin
            for (int j = 0; j < 5; j++) m8[j] <= 10'd0;
            for (int j = 0; j < 4; j++) m4[j] <= 10'd0;
            for (int j = 0; j < 3; j++) m2[j] <= 10'd0;
        end else if (i_en) begin
            for (int j = 1; j < 5; j++) m8[j] <= m8[j-1];
            for (int j = 1; j < 4; j++) m4[j] <= m4[j-1];
            for (int j = 1; j < 3; j++) m2[j] <= m2[j-1];
            m8[0] <= {i_valid, ref_add(8, a80 ^ a81, b80 ^ b81)};
            m4[0] <= {i_valid, ref_add(4, {4'h0, a40 ^ a41}, {4'h0, b40 ^ b41})};
            m2[0] <= {i_valid, ref_add(2, {6'h0, a20 ^ a21}, {6'h0, b20 ^ b21})};
        end
    end

    logic [18:0] prev8;
    logic [10:0] prev4;
    logic [6:0]  prev2;
    logic track = 1'b0, have = 1'b0, diff = 1'b0;
    logic [7:0] first_s0;

    always @(negedge clk) begin
        chk("valid8", 32'(ov8), 32'(m8[4][9]));
        if (m8[4][9]) begin
            chk("sum8",   32'(s80 ^ s81), 32'(m8[4][7:0]));
            chk("carry8", 32'(c80 ^ c81), 32'(m8[4][8]));
        end
        chk("valid4", 32'(ov4), 32'(m4[3][9]));
        if (m4[3][9]) begin
            chk("sum4",   32'(s40 ^ s41), 32'(m4[3][7:0]));
            chk("carry4", 32'(c40 ^ c41), 32'(m4[3][8]));
        end
        chk("valid2", 32'(ov2), 32'(m2[2][9]));
        if (m2[2][9]) begin
            chk("sum2",   32'(s20 ^ s21), 32'(m2[2][7:0]));
            chk("carry2", 32'(c20 ^ c21), 32'(m2[2][8]));
        end
        if (hold_q) begin
            chk("hold8", 32'({ov8, c80, c81, s80, s81}), 32'(prev8));
            chk("hold4", 32'({ov4, c40, c41, s40, s41}), 32'(prev4));
            chk("hold2", 32'({ov2, c20, c21, s20, s21}), 32'(prev2));
        end
        prev8 <= {ov8, c80, c81, s80, s81};
        prev4 <= {ov4, c40, c41, s40, s41};
        prev2 <= {ov2, c20, c21, s20, s21};
        if (track && ov8) begin
            if (!have) begin
                first_s0 <= s80;
                have     <= 1'b1;
            end else if (s80 != first_s0) begin
                diff <= 1'b1;
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] t;
        i_valid = v;
        t   = {$urandom, $urandom};
        a80 = t[7:0];   b80 = t[15:8];
        a40 = t[19:16]; b40 = t[23:20];
        a20 = t[25:24]; b20 = t[27:26];
        a81 = a80 ^ a;      b81 = b80 ^ b;
        a41 = a40 ^ a[3:0]; b41 = b40 ^ b[3:0];
        a21 = a20 ^ a[1:0]; b21 = b20 ^ b[1:0];
        t  = {$urandom, $urandom};
        r8 = t[55:0];
        t  = {$urandom, $urandom};
        r4 = t[19:0];
        r2 = t[25:20];
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        drive(v, a, b);
    endtask

    // One isolated op: checks latency and the literal sum/carry
    task automatic issue_and_check(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] es, input logic ec, input string name);
        logic found;
        found = 1'b0;
        step(1'b1, a, b);
        for (int n = 1; n <= 10 && !found; n++) begin
            step(1'b0, 8'h00, 8'h00);
            @(negedge clk);
            if (ov8) begin
                found = 1'b1;
                chk({name, "_lat"}, 32'(n), 32'd5);
                chk({name, "_sum"}, 32'(s80 ^ s81), 32'(es));
                chk({name, "_c"},   32'(c80 ^ c81), 32'(ec));
            end
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] t;
        rst  = 1'b1;
        i_en = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("reset_state", 32'({ov8, c80, c81, s80, s81}), 32'd0);
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b0;

        issue_and_check(8'h5A, 8'h3C, 8'h96, 1'b0, "t1");
        issue_and_check(8'hFF, 8'h01, 8'h00, 1'b1, "t2a");
        issue_and_check(8'h80, 8'h80, 8'h00, 1'b1, "t2b");
        issue_and_check(8'h00, 8'h00, 8'h00, 1'b0, "t2c");
        issue_and_check(8'hC8, 8'h64, 8'h2C, 1'b1, "t2d");

        track = 1'b1;
        for (int n = 0; n < 16; n++) step(1'b1, 8'h5A, 8'h3C);
        repeat (7) step(1'b0, 8'h00, 8'h00);
        track = 1'b0;
        chk("share_varies", 32'(diff), 32'd1);

        for (int n = 0; n < 1000; n++) begin
            t = $urandom;
            step(1'b1, t[7:0], t[15:8]);
        end
        repeat (7) step(1'b0, 8'h00, 8'h00);

        for (int n = 0; n < 4; n++) begin
            t = $urandom;
            step(1'b1, t[7:0], t[15:8]);
        end
        step(1'b1, 8'hAA, 8'h55);
        i_en = 1'b0;
        step(1'b1, 8'hAA, 8'h55);
        step(1'b1, 8'hAA, 8'h55);
        step(1'b0, 8'h00, 8'h00);
        i_en = 1'b1;
        repeat (8) step(1'b0, 8'h00, 8'h00);

        for (int n = 0; n < 3; n++) begin
            t = $urandom;
            step(1'b1, t[7:0], t[15:8]);
        end
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_out", 32'({ov8, c80, c81, s80, s81}), 32'd0);
        repeat (8) step(1'b0, 8'h00, 8'h00);

        for (int x = 0; x < 256; x++) begin
            t = 32'(x);
            step(1'b1, {4'h0, t[7:4]}, {4'h0, t[3:0]});
        end
        repeat (7) step(1'b0, 8'h00, 8'h00);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
